// File: rtl/fifo_rd_stream_if.sv
// FIFO pop side and valid/ready stream side of the read adapter, bundled as one interface.
// master = the adapter (pops the FIFO, drives the stream); slave = FIFO plus stream consumer.
interface fifo_rd_stream_if #(
  parameter int DW = 4
);
  logic          fifo_empty;
  logic [DW-1:0] fifo_dat;
  logic          fifo_ren;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;

  modport master (
    input  fifo_empty, fifo_dat, m_ready,
    output fifo_ren, m_valid, m_data
  );

  modport slave (
    output fifo_empty, fifo_dat, m_ready,
    input  fifo_ren, m_valid, m_data
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// Read-side adapter: turns a registered-data FIFO pop interface into a full-throughput valid/ready stream.
// Optional accepted-word counter (cnt_clr/rd_cnt) is built only when FIFO_RD_CNT_EN is defined.
module fifo_rd_stream #(
  parameter int DW = 4,
  parameter int CW = 16
) (
  input  logic            rclk,
  input  logic            rst_i,
`ifdef FIFO_RD_CNT_EN
  input  logic            cnt_clr,
  output logic [CW-1:0]   rd_cnt,
`endif
  fifo_rd_stream_if.master s
);

  logic [DW-1:0] buf0, buf1;
  logic [1:0]    occ;
  logic          infl;
  logic          pop;
  logic [1:0]    occ_pop;
  logic [1:0]    occ_nxt;
  logic          credit;

  assign pop     = (occ != 2'd0) & s.m_ready;
  assign occ_pop = occ - {1'b0, pop};
  assign occ_nxt = occ_pop + {1'b0, infl};
  // A new pop is allowed only if the word it returns will find a free slot.
  assign credit  = (occ_nxt < 2'd2);

  assign s.fifo_ren = ~rst_i & ~s.fifo_empty & credit;
  assign s.m_valid  = (occ != 2'd0);
  assign s.m_data   = buf0;

  // Buffer stage: shift on pop, then append the arriving word behind whatever remains.
  always_ff @(posedge rclk or posedge rst_i) begin
    if (rst_i) begin
      occ  <= 2'd0;
      infl <= 1'b0;
      buf0 <= '0;
      buf1 <= '0;
    end else begin
      infl <= s.fifo_ren;
      occ  <= occ_nxt;
      // Head only advances when a second entry exists, so an emptied buffer keeps m_data.
      if (pop && (occ == 2'd2))
        buf0 <= buf1;
      if (infl) begin
        if (occ_pop == 2'd0)
          buf0 <= s.fifo_dat;
        else
          buf1 <= s.fifo_dat;
      end
    end
  end

`ifdef FIFO_RD_CNT_EN
  always_ff @(posedge rclk or posedge rst_i) begin
    if (rst_i)
      rd_cnt <= '0;
    else if (cnt_clr)
      rd_cnt <= '0;
    else if (pop)
      rd_cnt <= rd_cnt + 1'b1;
  end
`endif

endmodule
